// File: rtl/addsub_pipe.sv
// addsub_pipe: pipelined two's-complement adder/subtractor.
// Operands are split into STAGES chunks of CW = WIDTH/STAGES bits. Each chunk is
// added in its own stage, and the carry is registered between stages.
// A global advance (adv = !out_valid | out_ready) moves every stage together.
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   in_valid / in_ready   operand beat handshake (in_ready = adv)
//   op_sub                0: a+b, 1: a-b (sampled with the beat)
//   data_a, data_b        operands
//   out_valid / out_ready result beat handshake
//   result                sum or difference modulo 2^WIDTH
//   c_out                 carry out of MSB (subtract: 1 = no borrow)
//   overflow              signed overflow
//   is_not_equal          result != 0
//   is_less_than          result[MSB] ^ overflow (signed a < b for subtract)
//
// WIDTH must be a multiple of STAGES.
module addsub_pipe #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             c_out,
    output logic             overflow,
    output logic             is_not_equal,
    output logic             is_less_than
);

    localparam int unsigned CW = WIDTH / STAGES;
    localparam int unsigned SW = CW + 1;

    // Rotate right by one chunk.
    function automatic logic [WIDTH-1:0] f_rot(input logic [WIDTH-1:0] x);
        return (x >> CW) | (x << (WIDTH - CW));
    endfunction

    // Replace the low chunk with its sum, then rotate. After STAGES steps, the
    // result chunks have cycled back into natural order. This way a single
    // WIDTH-bit register per stage carries both the unconsumed A chunks (skew)
    // and the finished result chunks (de-skew).
    function automatic logic [WIDTH-1:0] f_merge(input logic [WIDTH-1:0] x,
                                                 input logic [CW-1:0]    s);
        logic [WIDTH-1:0] m;
        m = ~({WIDTH{1'b1}} << CW);
        return f_rot((x & ~m) | (WIDTH'(s) & m));
    endfunction

    logic             w_adv;
    logic [WIDTH-1:0] w_binv;

    // Inputs to the final chunk adder.
    logic [WIDTH-1:0] w_fx;
    logic [CW-1:0]    w_fb;
    logic             w_fcin;
    logic             w_fv;

    assign w_adv    = !out_valid | out_ready;
    assign in_ready = w_adv;
    // Subtract is A + ~B + 1.
    assign w_binv   = data_b ^ {WIDTH{op_sub}};

    if (STAGES > 1) begin : g_pipe
        localparam int NP = int'(STAGES) - 1;

        logic             r_v  [NP];
        logic             r_cy [NP];
        logic [WIDTH-1:0] r_x  [NP];
        logic [WIDTH-1:0] r_b  [NP];

        logic [WIDTH-1:0] w_sx  [NP];
        logic [WIDTH-1:0] w_sb  [NP];
        logic             w_sc  [NP];
        logic             w_sv  [NP];
        logic [SW-1:0]    w_sum [NP];

        // Stage sources: stage 0 takes the input beat, stage k takes stage k-1.
        always_comb begin
            w_sx[0] = data_a;
            w_sb[0] = w_binv;
            w_sc[0] = op_sub;
            w_sv[0] = in_valid;
            for (int k = 1; k < NP; k++) begin
                w_sx[k] = r_x[k-1];
                w_sb[k] = r_b[k-1];
                w_sc[k] = r_cy[k-1];
                w_sv[k] = r_v[k-1];
            end
            for (int k = 0; k < NP; k++) begin
                w_sum[k] = {1'b0, w_sx[k][CW-1:0]} + {1'b0, w_sb[k][CW-1:0]} + SW'(w_sc[k]);
            end
        end

        // All stages shift together on adv; reset wins.
        always_ff @(posedge clock) begin
            if (reset) begin
                for (int k = 0; k < NP; k++) begin
                    r_v[k]  <= 1'b0;
                    r_cy[k] <= 1'b0;
                    r_x[k]  <= '0;
                    r_b[k]  <= '0;
                end
            end else if (w_adv) begin
                for (int k = 0; k < NP; k++) begin
                    r_v[k]  <= w_sv[k];
                    r_cy[k] <= w_sum[k][CW];
                    r_x[k]  <= f_merge(w_sx[k], w_sum[k][CW-1:0]);
                    r_b[k]  <= f_rot(w_sb[k]);
                end
            end
        end

        assign w_fx   = r_x[NP-1];
        assign w_fb   = r_b[NP-1][CW-1:0];
        assign w_fcin = r_cy[NP-1];
        assign w_fv   = r_v[NP-1];
    end else begin : g_flat
        assign w_fx   = data_a;
        assign w_fb   = w_binv[CW-1:0];
        assign w_fcin = op_sub;
        assign w_fv   = in_valid;
    end

    // Final chunk adder and flags.
    logic [SW-1:0]    w_fsum;
    logic [WIDTH-1:0] w_res;
    logic             w_cin_msb;
    logic             w_ovf;

    always_comb begin
        w_fsum    = {1'b0, w_fx[CW-1:0]} + {1'b0, w_fb} + SW'(w_fcin);
        w_res     = f_merge(w_fx, w_fsum[CW-1:0]);
        // Carry into the MSB is recovered from the MSB sum bit.
        w_cin_msb = w_fx[CW-1] ^ w_fb[CW-1] ^ w_fsum[CW-1];
        w_ovf     = w_cin_msb ^ w_fsum[CW];
    end

    logic             r_out_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_c_out;
    logic             r_overflow;
    logic             r_ne;
    logic             r_lt;

    // Output stage registers; these hold while stalled.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_c_out     <= 1'b0;
            r_overflow  <= 1'b0;
            r_ne        <= 1'b0;
            r_lt        <= 1'b0;
        end else if (w_adv) begin
            r_out_valid <= w_fv;
            r_result    <= w_res;
            r_c_out     <= w_fsum[CW];
            r_overflow  <= w_ovf;
            r_ne        <= |w_res;
            r_lt        <= w_res[WIDTH-1] ^ w_ovf;
        end
    end

    assign out_valid    = r_out_valid;
    assign result       = r_result;
    assign c_out        = r_c_out;
    assign overflow     = r_overflow;
    assign is_not_equal = r_ne;
    assign is_less_than = r_lt;

endmodule
